audio_stereo_in: RTL

AUDIO_STEREO_IN -- requirements
Module: audio_stereo_in

---
 rtl/audio_stereo_in_pkg.sv | 22 ++
 rtl/audio_stereo_in_if.sv | 22 ++
 rtl/audio_pdm_accum.sv | 44 ++++
 rtl/audio_stereo_in.sv | 125 ++++++++++++
 4 files changed

// File: rtl/audio_stereo_in_pkg.sv
// Shared types and constants for the stereo pulse-density capture block.
// Holds the FSM state enumeration and the packed stereo PCM sample word.
package audio_stereo_in_pkg;

  localparam int PCM_CH_BITS = 8;
  localparam int WINDOW_MAX  = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    ACCUM = 2'd2
  } audio_state_t;

  typedef logic [PCM_CH_BITS-1:0] pcm_ch_t;

  // Right channel occupies the upper byte of the word handed downstream.
  typedef struct packed {
    pcm_ch_t right;
    pcm_ch_t left;
  } stereo_pcm_t;

endpackage

// File: rtl/audio_stereo_in_if.sv
// PCM write port between the stereo capture block and its downstream FIFO.
// The master drives the sample word and strobe; the slave reports full.
interface audio_stereo_in_if;
  import audio_stereo_in_pkg::*;

  stereo_pcm_t stereo_pcm;
  logic        stereo_pcm_rdy;
  logic        fifo_full;

  modport master (
    output stereo_pcm,
    output stereo_pcm_rdy,
    input  fifo_full
  );

  modport slave (
    input  stereo_pcm,
    input  stereo_pcm_rdy,
    output fifo_full
  );

endinterface

// File: rtl/audio_pdm_accum.sv
// One channel of pulse-density capture: input synchronizer plus 8-bit
// ones-counter. 'sum' is the count including the bit seen this cycle.
module audio_pdm_accum
  import audio_stereo_in_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic    clk,
  input  logic    aclr,
  input  logic    pdm,
  input  logic    clear,
  input  logic    add,
  output pcm_ch_t sum
);

  logic [SYNC_STAGES-1:0] sync_q;
  pcm_ch_t                acc_q;
  logic                   bit_s;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pdm};
    end
  end

  assign bit_s = sync_q[SYNC_STAGES-1];
  assign sum   = acc_q + pcm_ch_t'(bit_s);

  // Clear wins over add so a completed window restarts from zero next edge.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (add) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/audio_stereo_in.sv
// Stereo pulse-density to 8-bit PCM capture with windowed ones-counting.
// Define AUDIO_STEREO_IN_DROP_CNT_EN to expose a saturating drop_count port.
module audio_stereo_in
  import audio_stereo_in_pkg::*;
#(
  parameter int WINDOW      = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                aclr,
  input  logic                left,
  input  logic                right,
  input  logic                enable,
  audio_stereo_in_if.master   pcm_if,
  output logic                busy
`ifdef AUDIO_STEREO_IN_DROP_CNT_EN
  ,
  output logic [7:0]          drop_count
`endif
);

  localparam logic [7:0] WIN_LAST  = 8'(WINDOW - 1);
  localparam logic [7:0] SYNC_LAST = 8'(SYNC_STAGES - 1);

  audio_state_t state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         done;
  logic         acc_clear;
  logic         acc_add;
  pcm_ch_t      sum_l, sum_r;

  audio_pdm_accum #(.SYNC_STAGES(SYNC_STAGES)) u_left (
    .clk   (clk),
    .aclr  (aclr),
    .pdm   (left),
    .clear (acc_clear),
    .add   (acc_add),
    .sum   (sum_l)
  );

  audio_pdm_accum #(.SYNC_STAGES(SYNC_STAGES)) u_right (
    .clk   (clk),
    .aclr  (aclr),
    .pdm   (right),
    .clear (acc_clear),
    .add   (acc_add),
    .sum   (sum_r)
  );

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = SYNC;
      end
      SYNC: begin
        // The counter doubles as the settle timer while synchronizers flush.
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == SYNC_LAST) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACCUM: begin
        // A window finishing on the same edge enable drops is still emitted.
        done  = (cnt_q == WIN_LAST);
        cnt_d = done ? 8'd0 : cnt_q + 8'd1;
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign acc_add   = (state_q == ACCUM);
  assign acc_clear = (state_q != ACCUM) || done;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      pcm_if.stereo_pcm     <= '0;
      pcm_if.stereo_pcm_rdy <= 1'b0;
    end else begin
      pcm_if.stereo_pcm_rdy <= done && !pcm_if.fifo_full;
      if (done) begin
        pcm_if.stereo_pcm <= '{right: sum_r, left: sum_l};
      end
    end
  end

`ifdef AUDIO_STEREO_IN_DROP_CNT_EN
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      drop_count <= '0;
    end else if (done && pcm_if.fifo_full && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule
